// File: rtl/seq_chk_pkg.sv
// Shared definitions for the step-sequence checker: FSM state encodings and
// default parameter values used by seq_step_checker and its sub-module.
package seq_chk_pkg;

  // FSM state encodings
  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  // Default configuration
  localparam int SEQ_CHK_WIDTH       = 6;
  localparam int SEQ_CHK_STEP        = 4;
  localparam int SEQ_CHK_LOCK_THRESH = 3;
  localparam int SEQ_CHK_LOSS_THRESH = 2;
  localparam int SEQ_CHK_ERR_CNT_W   = 8;

  // Counter width able to hold values 0..max_val (at least 1 bit)
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/seq_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear and async active-low reset.
// Holds at all-ones once reached; clear has priority over increment.
module seq_chk_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_step_checker.sv
// Receive-side monitor for a step-by-N counter stream. Locks onto the
// arithmetic sequence, flags out-of-sequence samples while locked and keeps a
// saturating error tally. All outputs are registered (1-cycle latency).
// Optional feature macro: SEQ_CHK_STICKY_EN adds the err_sticky output.
module seq_step_checker
  import seq_chk_pkg::*;
#(
  parameter int WIDTH       = SEQ_CHK_WIDTH,
  parameter int STEP        = SEQ_CHK_STEP,
  parameter int LOCK_THRESH = SEQ_CHK_LOCK_THRESH,
  parameter int LOSS_THRESH = SEQ_CHK_LOSS_THRESH,
  parameter int ERR_CNT_W   = SEQ_CHK_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_count,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected_next
`ifdef SEQ_CHK_STICKY_EN
  ,
  output logic                 err_sticky
`endif
);

  localparam int RUN_W  = cnt_width(LOCK_THRESH);
  localparam int MISS_W = cnt_width(LOSS_THRESH);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q, locked_d;
  logic [WIDTH-1:0] expected_next_q, expected_next_d;

  logic [RUN_W-1:0]  run_cnt;
  logic [MISS_W-1:0] miss_cnt;
  logic              run_clr, run_inc;
  logic              miss_clr, miss_inc;
  logic              err_inc;

  logic [WIDTH-1:0] step_sum;
  logic             match;
  logic             run_hit;
  logic             loss_hit;

  // Natural modulo-2^WIDTH wrap comes from the truncated sum
  assign step_sum = prev_q + STEP_W;
  assign match    = (in_count == step_sum);
  assign run_hit  = ((32'(run_cnt) + 32'd1) == 32'(LOCK_THRESH));
  assign loss_hit = ((32'(miss_cnt) + 32'd1) == 32'(LOSS_THRESH));

  // FSM next-state, sequence tracking and counter control
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    run_clr  = 1'b0;
    run_inc  = 1'b0;
    miss_clr = 1'b0;
    miss_inc = 1'b0;
    err_inc  = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          prev_d  = in_count;
          run_clr = 1'b1;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          prev_d = in_count;
          if (match) begin
            run_inc = 1'b1;
            if (run_hit) begin
              state_d  = LOCKED;
              miss_clr = 1'b1;
            end
          end else begin
            run_clr = 1'b1;
          end
        end
        LOCKED: begin
          if (match) begin
            prev_d   = in_count;
            miss_clr = 1'b1;
          end else begin
            // Flywheel: advance the reference so one bad sample costs one error
            err_inc  = 1'b1;
            miss_inc = 1'b1;
            prev_d   = step_sum;
            if (loss_hit) begin
              state_d = ACQUIRE;
              prev_d  = in_count;
              run_clr = 1'b1;
            end
          end
        end
        default: begin
          state_d = HUNT;
          prev_d  = '0;
        end
      endcase
    end
  end

  // Registered output values derived from the next state
  always_comb begin
    err_pulse_d     = err_inc;
    locked_d        = (state_d == LOCKED);
    expected_next_d = (state_d == HUNT) ? '0 : (prev_d + STEP_W);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= HUNT;
      prev_q          <= '0;
      err_pulse_q     <= 1'b0;
      locked_q        <= 1'b0;
      expected_next_q <= '0;
    end else begin
      state_q         <= state_d;
      prev_q          <= prev_d;
      err_pulse_q     <= err_pulse_d;
      locked_q        <= locked_d;
      expected_next_q <= expected_next_d;
    end
  end

  // Consecutive-match run length while acquiring
  seq_chk_sat_cnt #(.W(RUN_W)) u_run_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (run_clr),
    .inc  (run_inc),
    .cnt  (run_cnt)
  );

  // Consecutive-mismatch run length while locked
  seq_chk_sat_cnt #(.W(MISS_W)) u_miss_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (miss_clr),
    .inc  (miss_inc),
    .cnt  (miss_cnt)
  );

  // Saturating tally of mismatches seen while locked
  seq_chk_sat_cnt #(.W(ERR_CNT_W)) u_err_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (1'b0),
    .inc  (err_inc),
    .cnt  (err_count)
  );

  assign locked        = locked_q;
  assign err_pulse     = err_pulse_q;
  assign expected_next = expected_next_q;

`ifdef SEQ_CHK_STICKY_EN
  logic err_sticky_q, err_sticky_d;

  // Sticky error flag: set alongside err_pulse, cleared only by reset
  always_comb begin
    err_sticky_d = err_sticky_q | err_inc;
  end

  // Sticky flag register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_seq_step_checker.sv
// Directed bench for seq_step_checker. Two instances share the stimulus: the
// default build (ERR_CNT_W=8) and a narrow one (ERR_CNT_W=2) whose tally
// must saturate at 3.
module tb_seq_step_checker;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic [5:0] in_count;

  logic       locked, err_pulse;
  logic [7:0] err_count;
  logic [5:0] expected_next;
  logic       s_locked, s_err_pulse;
  logic [1:0] s_err_count;
  logic [5:0] s_expected_next;
`ifdef SEQ_CHK_STICKY_EN
  logic       err_sticky, s_err_sticky;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse = 0;

  seq_step_checker #(.WIDTH(6), .STEP(4), .LOCK_THRESH(3), .LOSS_THRESH(2), .ERR_CNT_W(8)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_count      (in_count),
    .locked        (locked),
    .err_pulse     (err_pulse),
    .err_count     (err_count),
    .expected_next (expected_next)
`ifdef SEQ_CHK_STICKY_EN
    ,
    .err_sticky    (err_sticky)
`endif
  );

  seq_step_checker #(.WIDTH(6), .STEP(4), .LOCK_THRESH(3), .LOSS_THRESH(2), .ERR_CNT_W(2)) dut_sat (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_count      (in_count),
    .locked        (s_locked),
    .err_pulse     (s_err_pulse),
    .err_count     (s_err_count),
    .expected_next (s_expected_next)
`ifdef SEQ_CHK_STICKY_EN
    ,
    .err_sticky    (s_err_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare both instances against one expected set; narrow tally = min(err,3)
  task automatic expect_out(input string tag, input logic lk, input logic pl,
                            input int err, input logic [5:0] nx);
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(pl));
    chk({tag, ".err_count"}, 32'(err_count), 32'(err));
    chk({tag, ".expected_next"}, 32'(expected_next), 32'(nx));
    chk({tag, ".sat_err_count"}, 32'(s_err_count), 32'((err > 3) ? 3 : err));
    chk({tag, ".sat_err_pulse"}, 32'(s_err_pulse), 32'(pl));
  endtask

  // Apply one cycle of stimulus; outputs are checked #1 after the edge
  task automatic step(input logic v, input logic [5:0] c);
    @(negedge clk);
    in_valid = v;
    in_count = c;
    @(posedge clk);
    #1;
    if (s_err_pulse) n_pulse++;
  endtask

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_count = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 1'b0, 0, 6'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Acquire and lock on 0,4,8,12
    step(1'b1, 6'd0);  expect_out("acq0", 1'b0, 1'b0, 0, 6'd4);
    step(1'b1, 6'd4);  expect_out("acq4", 1'b0, 1'b0, 0, 6'd8);
    step(1'b1, 6'd8);  expect_out("acq8", 1'b0, 1'b0, 0, 6'd12);
    step(1'b1, 6'd12); expect_out("lock12", 1'b1, 1'b0, 0, 6'd16);

    // Single glitch: 25 in place of 24 is flywheeled over
    step(1'b1, 6'd16); expect_out("run16", 1'b1, 1'b0, 0, 6'd20);
    step(1'b1, 6'd20); expect_out("run20", 1'b1, 1'b0, 0, 6'd24);
    step(1'b1, 6'd25); expect_out("glitch25", 1'b1, 1'b1, 1, 6'd28);
    step(1'b1, 6'd28); expect_out("fly28", 1'b1, 1'b0, 1, 6'd32);

    // Loss of lock on 7,9 then relock on 13,17,21
    step(1'b1, 6'd7);  expect_out("miss7", 1'b1, 1'b1, 2, 6'd36);
    step(1'b1, 6'd9);  expect_out("loss9", 1'b0, 1'b1, 3, 6'd13);
    step(1'b1, 6'd13); expect_out("reacq13", 1'b0, 1'b0, 3, 6'd17);
    step(1'b1, 6'd17); expect_out("reacq17", 1'b0, 1'b0, 3, 6'd21);
    step(1'b1, 6'd21); expect_out("relock21", 1'b1, 1'b0, 3, 6'd25);

    // Drop lock deliberately, re-lock on the even phase, then wrap 60 -> 0
    step(1'b1, 6'd40); expect_out("miss40", 1'b1, 1'b1, 4, 6'd29);
    step(1'b1, 6'd44); expect_out("loss44", 1'b0, 1'b1, 5, 6'd48);
    step(1'b1, 6'd48); expect_out("acq48", 1'b0, 1'b0, 5, 6'd52);
    step(1'b1, 6'd52); expect_out("acq52", 1'b0, 1'b0, 5, 6'd56);
    step(1'b1, 6'd56); expect_out("lock56", 1'b1, 1'b0, 5, 6'd60);
    step(1'b1, 6'd60); expect_out("wrap60", 1'b1, 1'b0, 5, 6'd0);
    step(1'b1, 6'd0);  expect_out("wrap0", 1'b1, 1'b0, 5, 6'd4);
    step(1'b1, 6'd4);  expect_out("wrap4", 1'b1, 1'b0, 5, 6'd8);

    // Idle gaps hold outputs; idle after a glitch clears err_pulse
    step(1'b0, 6'd33); expect_out("idle1", 1'b1, 1'b0, 5, 6'd8);
    step(1'b0, 6'd1);  expect_out("idle2", 1'b1, 1'b0, 5, 6'd8);
    step(1'b1, 6'd8);  expect_out("post_idle8", 1'b1, 1'b0, 5, 6'd12);
    step(1'b1, 6'd13); expect_out("glitch13", 1'b1, 1'b1, 6, 6'd16);
`ifdef SEQ_CHK_STICKY_EN
    chk("sticky_set", 32'(err_sticky), 32'd1);
`endif
    step(1'b0, 6'd0);  expect_out("idle_after_glitch", 1'b1, 1'b0, 6, 6'd16);
    step(1'b1, 6'd16); expect_out("match16", 1'b1, 1'b0, 6, 6'd20);

    // Five isolated glitches: narrow tally pins at 3, pulses keep coming
    n_pulse = 0;
    for (int i = 0; i < 5; i++) begin
      logic [5:0] e;
      e = 6'(20 + 8 * i);
      step(1'b1, e + 6'd1);
      expect_out("iso_glitch", 1'b1, 1'b1, 7 + i, e + 6'd4);
      step(1'b1, e + 6'd4);
      expect_out("iso_match", 1'b1, 1'b0, 7 + i, e + 6'd8);
    end
    chk("sat_pulse_count", 32'(n_pulse), 32'd5);

    // Asynchronous reset between clock edges clears everything at once
    #2;
    rstn = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 1'b0, 0, 6'd0);
`ifdef SEQ_CHK_STICKY_EN
    chk("sticky_rst", 32'(err_sticky), 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    step(1'b1, 6'd0);  expect_out("r_acq0", 1'b0, 1'b0, 0, 6'd4);
    step(1'b1, 6'd4);  expect_out("r_acq4", 1'b0, 1'b0, 0, 6'd8);
    step(1'b1, 6'd8);  expect_out("r_acq8", 1'b0, 1'b0, 0, 6'd12);
    step(1'b1, 6'd12); expect_out("r_lock12", 1'b1, 1'b0, 0, 6'd16);
`ifdef SEQ_CHK_STICKY_EN
    step(1'b1, 6'd17); expect_out("r_glitch17", 1'b1, 1'b1, 1, 6'd20);
    chk("sticky_after_glitch", 32'(err_sticky), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_step_checker.md
Name: seq_step_checker

Overview:
- Receive-side monitor for the step-by-N counter stream, e.g. a 6-bit count that advances by 4 every clock.
- Samples the count bus on a valid strobe and acquires lock onto the arithmetic sequence.
- Flags every out-of-sequence value and keeps a saturating error tally.
- Sits beside any step-counter instance as a synthesizable self-check. Outputs are used by the bench and by on-chip status logic.

Parameters:
- WIDTH, 6: width of the observed count bus.
- STEP, 4: expected increment per valid sample, modulo 2^WIDTH.
- LOCK_THRESH, 3: consecutive matching samples needed to enter LOCKED.
- LOSS_THRESH, 2: consecutive mismatches in LOCKED that drop lock.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  in_count is sampled on a rising edge where this is high.
- in_count  input  WIDTH  observed counter value.
- locked  output  1  high while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse for each mismatch detected in LOCKED.
- err_count  output  ERR_CNT_W  total mismatches in LOCKED; saturates at all-ones.
- expected_next  output  WIDTH  value expected on the next valid sample; 0 in HUNT.

Behaviour:
- Reset and clocking:
  - Asynchronous active-low reset, single clock domain.
  - While rstn=0: state=HUNT, prev=0, run=0, miss_run=0, locked=0, err_pulse=0, err_count=0, expected_next=0.
  - All outputs are registered. Response appears the cycle after the sampling edge (1-cycle latency).
- Idle cycles: in_valid=0 means no state change, err_pulse=0, and all other outputs hold.
- Match rule: a sample matches when in_count == (prev + STEP) mod 2^WIDTH. Wrap is natural modulo, so 60 followed by 0 is a match for WIDTH=6, STEP=4.
- HUNT:
  - On a valid sample: prev<=in_count, run<=0, go to ACQUIRE.
- ACQUIRE:
  - On a match: prev<=in_count, run<=run+1.
  - When run+1 == LOCK_THRESH: go to LOCKED with miss_run<=0.
  - On a mismatch: prev<=in_count, run<=0, stay in ACQUIRE.
  - No errors are counted in ACQUIRE.
- LOCKED:
  - On a match: prev<=in_count, miss_run<=0.
  - On a mismatch:
    - err_pulse=1 for one cycle.
    - err_count increments unless already all-ones.
    - prev<=prev+STEP (flywheel), so a single corrupted sample yields exactly one error.
    - miss_run<=miss_run+1.
  - When miss_run+1 == LOSS_THRESH: go to ACQUIRE with prev<=in_count and run<=0. The mismatch that drops lock is still counted.
- expected_next = prev+STEP in ACQUIRE and LOCKED; 0 in HUNT.
- Reset mid-operation aborts immediately. err_count is not retained.

Optional Feature:
- Macro: SEQ_CHK_STICKY_EN.
- Defined: adds output port err_sticky (1 bit).
  - Set on the cycle err_pulse asserts.
  - Cleared only by reset.
  - Unaffected by loss of lock.
- Undefined: port and register are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package/header seq_chk_pkg holds:
  - state encodings HUNT=2'd0, ACQUIRE=2'd1, LOCKED=2'd2;
  - default values for WIDTH, STEP, LOCK_THRESH, LOSS_THRESH, ERR_CNT_W.
- One natural sub-module: seq_chk_sat_cnt, a parameterized saturating up-counter with inc input and async active-low reset. It implements err_count and is reused for run and miss_run.

Test Plan:
1. Acquire and lock: valid samples 0,4,8,12 on consecutive cycles -> locked=1 the cycle after 12 is sampled; err_count=0; expected_next=16.
2. Wrap: once locked, feed 52,56,60,0,4 -> no err_pulse; locked stays 1; expected_next=8 after 4.
3. Single glitch: locked at 16, feed 20,25,28 -> err_pulse for exactly one cycle after 25; err_count=1; locked stays 1; 28 matches via flywheel (prev=24).
4. Loss of lock: locked at 32, feed 7,9 ->
   - err_count +2;
   - locked=0 after 9, state ACQUIRE with expected_next=13;
   - then 13,17,21 -> relock.
5. Idle gaps and saturation:
   - Insert in_valid=0 gaps mid-sequence -> outputs hold.
   - With ERR_CNT_W=2, force 5 isolated glitches while locked -> err_count stops at 3; err_pulse still fires 5 times.
6. Async reset: drop rstn between clock edges while locked with err_count=2 -> all outputs 0 immediately. After release, samples 0,4,8,12 relock. With SEQ_CHK_STICKY_EN, err_sticky is 0 after reset and 1 after the first glitch.
